// File: rtl/controlador_entrada_chaves_if.sv
// Decoder-facing bus of the switch input controller.
// Master = decoder/datapath side, slave = controlador_entrada_chaves.
interface controlador_entrada_chaves_if #(
    parameter int LARGURA_CHAVES = 14
);
    logic [1:0]                in;
    logic [LARGURA_CHAVES-1:0] dado_lido_entrada;
    logic                      aguardando_entrada;
    logic                      entrada_valida;

    modport master (
        output in,
        input  dado_lido_entrada,
        input  aguardando_entrada,
        input  entrada_valida
    );

    modport slave (
        input  in,
        output dado_lido_entrada,
        output aguardando_entrada,
        output entrada_valida
    );
endinterface

// File: rtl/controlador_entrada_chaves.sv
// Switch/confirm-button input controller for the IN instruction.
// Optional macro ENTRADA_DEBOUNCE_EN enables the button debounce counter.
module controlador_entrada_chaves #(
    parameter int LARGURA_CHAVES  = 14,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botao_confirma,
    controlador_entrada_chaves_if.slave bus
);

    if (DEBOUNCE_CICLOS < 2) begin : g_debounce_ciclos_invalido
        $error("DEBOUNCE_CICLOS must be at least 2");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA_PRESS,
        CONCLUIDO,
        AGUARDA_SOLTA
    } estado_t;

    estado_t estado;
    estado_t estado_prox;

    logic [LARGURA_CHAVES-1:0] chaves_s1;
    logic [LARGURA_CHAVES-1:0] chaves_s2;
    logic [LARGURA_CHAVES-1:0] dado_q;
    logic                      botao_s1;
    logic                      botao_s2;
    logic                      nivel_q;
    logic                      nivel_prox;
    logic                      evento_press;
    logic                      evento_solta;
    logic                      pedido;
    logic                      captura;

    assign pedido = (bus.in == 2'd1);

    // two-flop synchronizers; button idles released (high)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chaves_s1 <= '0;
            chaves_s2 <= '0;
            botao_s1  <= 1'b1;
            botao_s2  <= 1'b1;
        end else begin
            chaves_s1 <= chaves;
            chaves_s2 <= chaves_s1;
            botao_s1  <= botao_confirma;
            botao_s2  <= botao_s1;
        end
    end

`ifdef ENTRADA_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

    logic [CW-1:0] cont_q;
    logic          difere;

    assign difere     = (botao_s2 != nivel_q);
    assign nivel_prox = (difere && cont_q == LIMITE) ? botao_s2 : nivel_q;

    // debounce: level flips after DEBOUNCE_CICLOS disagreeing cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q  <= '0;
            nivel_q <= 1'b1;
        end else begin
            nivel_q <= nivel_prox;
            if (!difere || cont_q == LIMITE) begin
                cont_q <= '0;
            end else begin
                cont_q <= cont_q + 1'b1;
            end
        end
    end
`else
    // keys already debounced externally: level is the synchronizer output
    assign nivel_q    = botao_s2;
    assign nivel_prox = botao_s1;
`endif

    // edges of the debounced level, seen one cycle before they land
    assign evento_press = nivel_q & ~nivel_prox;
    assign evento_solta = ~nivel_q & nivel_prox;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // next-state and latch decision
    always_comb begin
        estado_prox = estado;
        captura     = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (pedido) begin
                    estado_prox = AGUARDA_PRESS;
                end
            end
            AGUARDA_PRESS: begin
                if (!pedido) begin
                    estado_prox = OCIOSO;
                end else if (evento_press) begin
                    estado_prox = CONCLUIDO;
                    captura     = 1'b1;
                end
            end
            CONCLUIDO: begin
                estado_prox = nivel_q ? OCIOSO : AGUARDA_SOLTA;
            end
            AGUARDA_SOLTA: begin
                if (evento_solta || nivel_q) begin
                    estado_prox = pedido ? AGUARDA_PRESS : OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // captured switch value, held until the next accepted press
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dado_q <= '0;
        end else if (captura) begin
            dado_q <= chaves_s2;
        end
    end

    assign bus.dado_lido_entrada  = dado_q;
    assign bus.entrada_valida     = (estado == CONCLUIDO);
    assign bus.aguardando_entrada = pedido && (estado != CONCLUIDO);

endmodule

// File: tb/tb_controlador_entrada_chaves.sv
// Bench for controlador_entrada_chaves: behavioural model plus
// directed scenarios with literal latency/value expectations.
module tb_controlador_entrada_chaves;

    localparam int W = 14;
    localparam int D = 4;
`ifdef ENTRADA_DEBOUNCE_EN
    localparam int LAT  = D + 2;
    localparam int JAN  = D;
    localparam int BASE = 1;
    localparam int NG   = 0;
    localparam int NB   = 1;
`else
    localparam int LAT  = 2;
    localparam int JAN  = 1;
    localparam int BASE = 0;
    localparam int NG   = 2;
    localparam int NB   = 3;
`endif

    logic         clock;
    logic         reset_n;
    logic [W-1:0] chaves;
    logic         botao;

    int total = 0;
    int bad   = 0;
    int npulsos = 0;

    controlador_entrada_chaves_if #(.LARGURA_CHAVES(W)) bus ();

    controlador_entrada_chaves #(
        .LARGURA_CHAVES (W),
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .chaves        (chaves),
        .botao_confirma(botao),
        .bus           (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nome, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nome, got, exp, $time);
        end
    endtask

    // model: raw sample history, debounced level, request phase
    logic         hb [0:7];
    logic [W-1:0] hc [0:1];
    logic         m_nivel;
    logic         m_novo;
    logic         m_todos;
    logic         m_press;
    logic         m_solta;
    logic         m_pede;
    int           m_fase;   // 0 idle, 1 waiting press, 2 done, 3 waiting release
    logic [W-1:0] m_dado;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) hb[i] = 1'b1;
            hc[0]   = '0;
            hc[1]   = '0;
            m_nivel = 1'b1;
            m_fase  = 0;
            m_dado  = '0;
        end else begin
            m_todos = 1'b1;
            for (int i = 0; i < JAN; i++)
                if (hb[BASE+i] == m_nivel) m_todos = 1'b0;
            m_novo  = m_todos ? ~m_nivel : m_nivel;
            m_press = m_nivel && !m_novo;
            m_solta = !m_nivel && m_novo;
            m_pede  = (bus.in == 2'd1);
            case (m_fase)
                0: if (m_pede) m_fase = 1;
                1: begin
                    if (!m_pede) m_fase = 0;
                    else if (m_press) begin
                        m_dado = hc[1];
                        m_fase = 2;
                    end
                end
                2: m_fase = m_nivel ? 0 : 3;
                default: if (m_solta || m_nivel) m_fase = m_pede ? 1 : 0;
            endcase
            m_nivel = m_novo;
            for (int i = 7; i > 0; i--) hb[i] = hb[i-1];
            hb[0] = botao;
            hc[1] = hc[0];
            hc[0] = chaves;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clock) begin
        chk("m_dado", 32'(bus.dado_lido_entrada), 32'(m_dado));
        chk("m_valida", 32'(bus.entrada_valida), 32'(m_fase == 2));
        chk("m_aguarda", 32'(bus.aguardando_entrada),
            32'((bus.in == 2'd1) && (m_fase != 2)));
        if (bus.entrada_valida) npulsos++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic espera_valida(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (bus.entrada_valida) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    int p0;
    int k;

    initial begin
        reset_n = 1'b0;
        bus.in  = 2'd0;
        chaves  = 14'h3FFF;
        botao   = 1'b1;
        step(3);
        chk("rst_dado", 32'(bus.dado_lido_entrada), 32'h0);
        chk("rst_valida", 32'(bus.entrada_valida), 32'h0);
        chk("rst_aguarda", 32'(bus.aguardando_entrada), 32'h0);
        reset_n = 1'b1;
        step(3);

        // basic IN
        chaves = 14'h1234;
        step(3);
        bus.in = 2'd1;
        #1 chk("aguarda_imediato", 32'(bus.aguardando_entrada), 32'h1);
        step(2);
        botao = 1'b0;
        espera_valida(n);
        chk("lat_basico", n, LAT);
        chk("dado_basico", 32'(bus.dado_lido_entrada), 32'h1234);
        chk("aguarda_concl", 32'(bus.aguardando_entrada), 32'h0);
        step(1);
        bus.in = 2'd0;
        step(20);
        botao = 1'b1;
        step(10);

        // bounce
        bus.in = 2'd1;
        chaves = 14'h2222;
        step(3);
        p0 = npulsos;
        botao = 1'b0; step(2);
        botao = 1'b1; step(2);
        botao = 1'b0; step(2);
        botao = 1'b1; step(2);
        chk("glitch_pulsos", npulsos - p0, NG);
        botao = 1'b0; step(15);
        chk("bounce_pulsos", npulsos - p0, NB);
        chk("bounce_dado", 32'(bus.dado_lido_entrada), 32'h2222);
        bus.in = 2'd0;
        botao = 1'b1;
        step(10);

        // back-to-back IN, button held
        bus.in = 2'd1;
        chaves = 14'h1111;
        step(3);
        botao = 1'b0;
        espera_valida(n);
        chk("lat_b2b1", n, LAT);
        chk("dado_b2b1", 32'(bus.dado_lido_entrada), 32'h1111);
        chaves = 14'h0ABC;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("b2b_presa_aguarda", 32'(bus.aguardando_entrada), 32'h1);
            chk("b2b_presa_valida", 32'(bus.entrada_valida), 32'h0);
        end
        chk("b2b_dado_mantido", 32'(bus.dado_lido_entrada), 32'h1111);
        botao = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("b2b_solta_aguarda", 32'(bus.aguardando_entrada), 32'h1);
        end
        botao = 1'b0;
        espera_valida(n);
        chk("lat_b2b2", n, LAT);
        chk("dado_b2b2", 32'(bus.dado_lido_entrada), 32'h0ABC);
        step(1);
        bus.in = 2'd0;
        botao = 1'b1;
        step(10);

        // reset in the middle of a wait
        bus.in = 2'd1;
        chaves = 14'h0555;
        step(3);
        botao = 1'b0;
        k = (LAT > 3) ? LAT - 3 : 0;
        repeat (k) @(posedge clock);
        #1;
        p0 = npulsos;
        reset_n = 1'b0;
        #1;
        chk("abort_dado", 32'(bus.dado_lido_entrada), 32'h0);
        chk("abort_valida", 32'(bus.entrada_valida), 32'h0);
        chk("abort_aguarda", 32'(bus.aguardando_entrada), 32'h1);
        botao = 1'b1;
        bus.in = 2'd0;
        step(3);
        reset_n = 1'b1;
        step(12);
        chk("abort_pulsos", npulsos - p0, 0);
        chk("abort_dado_fim", 32'(bus.dado_lido_entrada), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controlador_entrada_chaves.md
Name: controlador_entrada_chaves

Overview:
Upstream stage of the input multiplexer: owns the physical switches and the confirm pushbutton, and produces the 14-bit dado_lido_entrada that the mux zero-extends into the datapath.
- When the decoder asserts in == 2'd1 (IN instruction), the block stalls the processor until the user presses the confirm button.
- On the press it latches the switch value, then releases the stall for exactly one cycle.
- Button and switches are synchronized; the button is debounced.

Parameters:
LARGURA_CHAVES, 14, width of switch bus and dado_lido_entrada
DEBOUNCE_CICLOS, 50000, consecutive stable cycles (post-synchronizer) required to accept a button level change (1 ms at 50 MHz); minimum 2

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
chaves  input  LARGURA_CHAVES  raw switch levels, asynchronous
botao_confirma  input  1  raw pushbutton, active-low (0 = pressed), asynchronous, bouncy
in  input  2  control from decoder; 2'd1 = IN instruction, other values = no input request
dado_lido_entrada  output  LARGURA_CHAVES  last latched switch value, registered
aguardando_entrada  output  1  stall request to PC/register-file write enable, combinational
entrada_valida  output  1  one-cycle pulse: dado_lido_entrada holds fresh data this cycle

Behaviour:
Reset (reset_n = 0, takes effect immediately, at any time including mid-wait):
- dado_lido_entrada = 0, entrada_valida = 0, state = OCIOSO.
- Button synchronizer and debounced level = 1 (released); debounce counter = 0; switch synchronizer = 0.
- aguardando_entrada follows its combinational rule (see below).

Synchronization:
- Two-flop synchronizer on botao_confirma and on every chaves bit.

Debounce:
- Counter increments each cycle the synchronized button differs from the debounced level; it clears when they are equal.
- When the counter reaches DEBOUNCE_CICLOS-1 while still different, the debounced level flips and the counter clears.
- Press latency from raw edge: 2 + DEBOUNCE_CICLOS cycles. Glitches shorter than DEBOUNCE_CICLOS are ignored.
- evento_press = debounced level goes 1->0 this cycle; evento_solta = debounced level goes 0->1.

FSM:
- OCIOSO: in==1 -> AGUARDA_PRESS, else stay. A press while OCIOSO is ignored, no latch; the FSM still tracks the release via the debounced level.
- AGUARDA_PRESS:
  - evento_press and in==1 -> latch synchronized chaves into dado_lido_entrada, go to CONCLUIDO.
  - in!=1 -> OCIOSO (request withdrawn), no latch.
- CONCLUIDO (exactly one cycle): entrada_valida = 1. Next state is AGUARDA_SOLTA if debounced level = 0, else OCIOSO.
- AGUARDA_SOLTA: waits for the debounced release.
  - On evento_solta or debounced level = 1: next state is AGUARDA_PRESS if in==1, else OCIOSO.
  - One press therefore never satisfies two consecutive IN instructions.

Outputs:
- aguardando_entrada = (in == 2'd1) && (state != CONCLUIDO). It is therefore 1 in the same cycle in rises, with no added latency. in == 2'd2 and 2'd3 are treated as 0.
- dado_lido_entrada holds its value outside the latch event and is never cleared except by reset.

Optional Feature:
Macro: ENTRADA_DEBOUNCE_EN
- Defined: debounce counter as specified above.
- Undefined: counter and DEBOUNCE_CICLOS logic removed; the debounced level equals the synchronized button, so press latency = 2 cycles. Intended for fast simulation and for boards with hardware-debounced keys.
- FSM, synchronizers and port list are identical in both builds.

Test Plan:
(Debounce-enabled runs use DEBOUNCE_CICLOS = 4.)
1. Reset: reset_n=0, chaves=14'h3FFF -> dado_lido_entrada=0, entrada_valida=0, aguardando_entrada=0 while in=0.
2. Basic IN: in=1, chaves=14'h1234, clean press held 20 cycles -> aguardando_entrada=1 from cycle 0; press accepted at 2+4 cycles; one cycle with dado_lido_entrada=14'h1234, entrada_valida=1, aguardando_entrada=0; then in=0 -> OCIOSO.
3. Bounce rejection: press toggled 1,0,1,0 for 2 cycles each, then held 0 -> only one latch; entrada_valida pulses once; no latch during the glitches.
4. Back-to-back IN: in held 1 across two instructions while the button stays pressed -> second instruction stalls (aguardando_entrada=1) until release plus a new press; new chaves=14'h0ABC is latched on the second press only.
5. Mid-wait abort: in=1, then reset_n pulsed low 3 cycles before an accepted press -> outputs return to reset values asynchronously; FSM=OCIOSO; no entrada_valida pulse.
6. Build without ENTRADA_DEBOUNCE_EN: repeat scenario 2 -> press accepted 2 cycles after the raw edge; scenario 3 yields one latch per synchronized falling edge.
